// File: rtl/vx_perf_sampler.sv
// vx_perf_sampler
//   Captures all perf counters into a shadow bank on a periodic tick or an
//   explicit trigger, then streams the bank out one counter per beat over a
//   valid/ready port. Each beat carries either the absolute value or the
//   difference from the previous snapshot.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   ctr_in                live counters, counter i at [i*CTR_W +: CTR_W]
//   enable, interval      periodic timer control (interval 0 = timer off)
//   trigger               one-cycle immediate sample request
//   delta_mode            1 = snapshot minus previous snapshot, 0 = absolute
//   out_valid/out_ready   beat handshake
//   out_data/out_index    beat payload and counter index
//   out_last              beat carries index NUM_CTRS-1
//   sample_id             completed drains (wraps)
//   overruns              dropped requests (saturates)
//   busy                  drain in progress
module vx_perf_sampler #(
   parameter int unsigned CTR_W      = 44,
   parameter int unsigned NUM_CTRS   = 8,
   parameter int unsigned INTERVAL_W = 16
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_CTRS*CTR_W-1:0]     ctr_in,
   input  logic                          enable,
   input  logic [INTERVAL_W-1:0]         interval,
   input  logic                          trigger,
   input  logic                          delta_mode,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [CTR_W-1:0]              out_data,
   output logic [$clog2(NUM_CTRS)-1:0]   out_index,
   output logic                          out_last,
   output logic [15:0]                   sample_id,
   output logic [15:0]                   overruns,
   output logic                          busy
);

   localparam int unsigned       IDX_W    = $clog2(NUM_CTRS);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CTRS - 1);

   typedef enum logic {ST_IDLE, ST_DRAIN} state_t;

   state_t                       state_q, state_d;
   logic [IDX_W-1:0]             idx_q, idx_d;
   logic [NUM_CTRS*CTR_W-1:0]    snap_q, snap_d;
   logic [NUM_CTRS*CTR_W-1:0]    base_q, base_d;
   logic [INTERVAL_W-1:0]        timer_q, timer_d;
   logic                         enable_q, enable_d;
   logic [15:0]                  sample_id_q, sample_id_d;
   logic [15:0]                  overruns_q, overruns_d;

   logic [CTR_W-1:0]             snap_arr [NUM_CTRS];
   logic [CTR_W-1:0]             base_arr [NUM_CTRS];
   logic [INTERVAL_W-1:0]        timer_cur;
   logic                         enable_rise;
   logic                         tick;
   logic                         req;
   logic                         last_hs;
   logic                         accept;
   logic                         drop;

   always_comb begin
      for (int unsigned i = 0; i < NUM_CTRS; i++) begin
         snap_arr[i] = snap_q[i*CTR_W +: CTR_W];
         base_arr[i] = base_q[i*CTR_W +: CTR_W];
      end
   end

   // The reload on an enable rise is applied combinationally so the rise
   // cycle already counts as the first cycle of the period: with interval N
   // the first tick lands N-1 cycles after the rise, then every N cycles.
   always_comb begin
      enable_rise = enable & ~enable_q;
      enable_d    = enable;
      timer_cur   = enable_rise ? (interval - INTERVAL_W'(1)) : timer_q;
      timer_d     = timer_q;
      tick        = 1'b0;
      if (enable) begin
         if (interval != '0) begin
            if (timer_cur == '0) begin
               tick    = 1'b1;
               timer_d = interval - INTERVAL_W'(1);
            end else begin
               timer_d = timer_cur - INTERVAL_W'(1);
            end
         end else begin
            timer_d = timer_cur;
         end
      end
   end

   always_comb begin
      req     = trigger | tick;
      last_hs = (state_q == ST_DRAIN) && out_ready && (idx_q == LAST_IDX);
      accept  = req && ((state_q == ST_IDLE) || last_hs);
      drop    = req && (state_q == ST_DRAIN) && !last_hs;

      state_d     = state_q;
      idx_d       = idx_q;
      snap_d      = snap_q;
      base_d      = base_q;
      sample_id_d = sample_id_q;
      overruns_d  = overruns_q;

      if (state_q == ST_DRAIN && out_ready) begin
         if (idx_q == LAST_IDX) begin
            state_d     = ST_IDLE;
            idx_d       = '0;
            sample_id_d = sample_id_q + 16'd1;
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end

      // Accept overrides the return to IDLE on the final handshake.
      if (accept) begin
         snap_d  = ctr_in;
         base_d  = snap_q;
         idx_d   = '0;
         state_d = ST_DRAIN;
      end

      if (drop && overruns_q != '1) begin
         overruns_d = overruns_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         snap_q      <= '0;
         base_q      <= '0;
         timer_q     <= '0;
         enable_q    <= 1'b0;
         sample_id_q <= '0;
         overruns_q  <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         snap_q      <= snap_d;
         base_q      <= base_d;
         timer_q     <= timer_d;
         enable_q    <= enable_d;
         sample_id_q <= sample_id_d;
         overruns_q  <= overruns_d;
      end
   end

   always_comb begin
      out_valid = (state_q == ST_DRAIN);
      busy      = out_valid;
      out_index = idx_q;
      out_last  = out_valid && (idx_q == LAST_IDX);
      out_data  = '0;
      if (out_valid) begin
         out_data = delta_mode ? (snap_arr[idx_q] - base_arr[idx_q]) : snap_arr[idx_q];
      end
      sample_id = sample_id_q;
      overruns  = overruns_q;
   end

endmodule
